// File: rtl/color_adj_ctrl.sv
// color_adj_ctrl: debounced keys (sel/up/dn/clr, active-low) drive a channel-select FSM and shadow gain levels; on vs_in rise the shadows are committed to rgb/r/g/b_lvl; sel_state and upd_pending report status
module color_adj_ctrl #(
  parameter int DEB_CNT    = 500_000,
  parameter int REPEAT_CNT = 5_000_000,
  parameter int LVL_W      = 3,
  parameter int LVL_MAX    = 7,
  parameter int LVL_DEF    = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             key_sel,
  input  logic             key_up,
  input  logic             key_dn,
  input  logic             key_clr,
  input  logic             vs_in,
  output logic [LVL_W-1:0] rgb_lvl,
  output logic [LVL_W-1:0] r_lvl,
  output logic [LVL_W-1:0] g_lvl,
  output logic [LVL_W-1:0] b_lvl,
  output logic [1:0]       sel_state,
  output logic             upd_pending
);
  localparam int SAT = DEB_CNT + REPEAT_CNT;
  localparam int CW = $clog2(SAT + 1);
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [3:0] RPT_EN = 4'b0110;
  localparam logic [LVL_W-1:0] MAXV = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] DEFV = LVL_W'(LVL_DEF);
  typedef enum logic [1:0] {SEL_RGB, SEL_R, SEL_G, SEL_B} sel_t;
  sel_t sel;
  logic [3:0] key_m, key_s, pls;
  logic [3:0][LVL_W-1:0] sh, lv;
  logic [LVL_W-1:0] cur;
  logic vs_d;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      key_m <= '1;
      key_s <= '1;
    end else begin
      key_m <= {key_clr, key_dn, key_up, key_sel};
      key_s <= key_m;
    end
  for (genvar i = 0; i < 4; i++) begin : g_key
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst || key_s[i]) begin
        cnt  <= '0;
        rcnt <= '0;
      end else begin
        cnt  <= (cnt == CW'(SAT)) ? cnt : cnt + 1'b1;
        rcnt <= (cnt != CW'(SAT) || rcnt == RW'(REPEAT_CNT - 1)) ? '0 : rcnt + 1'b1;
      end
    // first repeat lands REPEAT_CNT after the press, just before saturation; later ones come from rcnt
    assign pls[i] = ~key_s[i] & ((cnt == CW'(DEB_CNT - 1)) |
                    (RPT_EN[i] & ((cnt == CW'(SAT - 1)) |
                    (cnt == CW'(SAT) && rcnt == RW'(REPEAT_CNT - 1)))));
  end
  assign cur = sh[sel];
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      sh          <= {4{DEFV}};
      lv          <= {4{DEFV}};
      sel         <= SEL_RGB;
      vs_d        <= 1'b0;
      upd_pending <= 1'b0;
    end else begin
      vs_d        <= vs_in;
      upd_pending <= sh != lv;
      if (vs_in & ~vs_d) lv <= sh;
      if (pls[3]) begin
        sh  <= {4{DEFV}};
        sel <= SEL_RGB;
      end else begin
        if (pls[1] ^ pls[2])
          sh[sel] <= pls[1] ? ((cur == MAXV) ? cur : cur + 1'b1) : ((cur == '0) ? cur : cur - 1'b1);
        if (pls[0]) sel <= sel_t'(sel + 2'd1);
      end
    end
  assign {b_lvl, g_lvl, r_lvl, rgb_lvl} = lv;
  assign sel_state = sel;
endmodule

// File: tb/tb_color_adj_ctrl.sv
// tb_color_adj_ctrl: scenario tasks against a press-length-based model of the key controller
module tb_color_adj_ctrl;
  localparam int DEB = 4;
  localparam int RPT = 8;
  localparam int LW = 3;
  localparam int LMAX = 7;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic vs_in = 1'b0;
  logic [3:0] keys = 4'hF;
  logic [LW-1:0] rgb_lvl, r_lvl, g_lvl, b_lvl;
  logic [1:0] sel_state;
  logic upd_pending;
  int errors = 0;
  int checks = 0;
  int m_sh[4];
  int m_lv[4];
  int m_sel;
  always #5 sys_clk = ~sys_clk;
  color_adj_ctrl #(.DEB_CNT(DEB), .REPEAT_CNT(RPT), .LVL_W(LW), .LVL_MAX(LMAX), .LVL_DEF(0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .key_sel(keys[0]), .key_up(keys[1]), .key_dn(keys[2]), .key_clr(keys[3]),
    .vs_in(vs_in),
    .rgb_lvl(rgb_lvl), .r_lvl(r_lvl), .g_lvl(g_lvl), .b_lvl(b_lvl),
    .sel_state(sel_state), .upd_pending(upd_pending)
  );
  function automatic logic [4*LW-1:0] exp_live();
    return {LW'(m_lv[3]), LW'(m_lv[2]), LW'(m_lv[1]), LW'(m_lv[0])};
  endfunction
  function automatic logic exp_pend();
    for (int i = 0; i < 4; i++) if (m_sh[i] != m_lv[i]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = 0;
      m_lv[i] = 0;
    end
    m_sel = 0;
  endfunction
  // A key held low n synchronised cycles presses on its DEB-th low cycle; up/dn then repeat every RPT
  function automatic void apply(input logic [3:0] mask, input int n);
    for (int t = 0; t < n; t++) begin
      bit press, rep, s, u, d, c;
      press = (t == DEB - 1);
      rep = (t > DEB - 1) && ((t - (DEB - 1)) % RPT == 0);
      s = mask[0] && press;
      u = mask[1] && (press || rep);
      d = mask[2] && (press || rep);
      c = mask[3] && press;
      if (c) begin
        for (int i = 0; i < 4; i++) m_sh[i] = 0;
        m_sel = 0;
      end else begin
        if (u && !d) m_sh[m_sel] = (m_sh[m_sel] + 1 > LMAX) ? LMAX : m_sh[m_sel] + 1;
        if (d && !u) m_sh[m_sel] = (m_sh[m_sel] - 1 < 0) ? 0 : m_sh[m_sel] - 1;
        if (s) m_sel = (m_sel + 1) % 4;
      end
    end
  endfunction
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic hold(input logic [3:0] mask, input int n);
    keys = ~mask;
    repeat (n) tick();
    keys = 4'hF;
    repeat (4) tick();
    apply(mask, n);
  endtask
  task automatic commit(input string tag);
    checks++;
    if ({b_lvl, g_lvl, r_lvl, rgb_lvl} !== exp_live()) begin
      errors++;
      $display("FAIL %s live_pre: got %h want %h", tag, {b_lvl, g_lvl, r_lvl, rgb_lvl}, exp_live());
    end
    checks++;
    if (upd_pending !== exp_pend()) begin
      errors++;
      $display("FAIL %s pend_pre: got %b want %b", tag, upd_pending, exp_pend());
    end
    vs_in = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) m_lv[i] = m_sh[i];
    checks++;
    if ({b_lvl, g_lvl, r_lvl, rgb_lvl} !== exp_live()) begin
      errors++;
      $display("FAIL %s live_post: got %h want %h", tag, {b_lvl, g_lvl, r_lvl, rgb_lvl}, exp_live());
    end
    tick();
    checks++;
    if (upd_pending !== 1'b0) begin
      errors++;
      $display("FAIL %s pend_post: got %b want 0", tag, upd_pending);
    end
    vs_in = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({b_lvl, g_lvl, r_lvl, rgb_lvl} !== '0) begin
      errors++;
      $display("FAIL reset_live: got %h want 0", {b_lvl, g_lvl, r_lvl, rgb_lvl});
    end
    checks++;
    if (sel_state !== 2'd0 || upd_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got sel=%0d pend=%b want sel=0 pend=0", sel_state, upd_pending);
    end
    sys_rst = 1'b0;
    tick();
  endtask
  task automatic test_glitch();
    hold(4'b0010, DEB - 1);
    commit("glitch");
  endtask
  task automatic test_press_commit();
    hold(4'b0010, 6);
    commit("press");
  endtask
  task automatic test_repeat();
    hold(4'b0001, 5);
    hold(4'b0001, 5);
    hold(4'b0010, 40);
    checks++;
    if (sel_state !== 2'(m_sel)) begin
      errors++;
      $display("FAIL repeat_sel: got %0d want %0d", sel_state, m_sel);
    end
    commit("repeat");
  endtask
  task automatic test_saturation();
    hold(4'b0010, 30);
    hold(4'b0010, 5);
    hold(4'b0001, 5);
    hold(4'b0100, 5);
    checks++;
    if (sel_state !== 2'(m_sel)) begin
      errors++;
      $display("FAIL sat_sel: got %0d want %0d", sel_state, m_sel);
    end
    commit("sat");
  endtask
  task automatic test_simultaneous();
    hold(4'b0001, 5);
    hold(4'b0110, 5);
    hold(4'b0011, 5);
    checks++;
    if (sel_state !== 2'(m_sel)) begin
      errors++;
      $display("FAIL sim_sel_up: got %0d want %0d", sel_state, m_sel);
    end
    commit("sim_updn");
    hold(4'b1010, 5);
    checks++;
    if (sel_state !== 2'(m_sel)) begin
      errors++;
      $display("FAIL sim_clr_sel: got %0d want %0d", sel_state, m_sel);
    end
    commit("sim_clr");
  endtask
  task automatic test_commit_timing();
    hold(4'b1000, 5);
    commit("ct_base");
    keys[1] = 1'b0;
    // press pulse lands DEB+1 edges after the key drops; raise vsync so its rise shares that cycle
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == DEB + 1) vs_in = 1'b1;
    end
    for (int i = 0; i < 4; i++) m_lv[i] = m_sh[i];
    apply(4'b0010, 6);
    checks++;
    if ({b_lvl, g_lvl, r_lvl, rgb_lvl} !== exp_live()) begin
      errors++;
      $display("FAIL ct_same_cycle: got %h want %h", {b_lvl, g_lvl, r_lvl, rgb_lvl}, exp_live());
    end
    keys = 4'hF;
    repeat (4) tick();
    checks++;
    if ({b_lvl, g_lvl, r_lvl, rgb_lvl} !== exp_live() || upd_pending !== exp_pend()) begin
      errors++;
      $display("FAIL ct_vs_high: got live=%h pend=%b want live=%h pend=%b",
               {b_lvl, g_lvl, r_lvl, rgb_lvl}, upd_pending, exp_live(), exp_pend());
    end
    vs_in = 1'b0;
    tick();
    commit("ct_next");
  endtask
  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      logic [3:0] mask;
      int n;
      mask = 4'($urandom_range(1, 15));
      n = $urandom_range(1, 30);
      hold(mask, n);
      checks++;
      if (sel_state !== 2'(m_sel)) begin
        errors++;
        $display("FAIL rnd_sel k=%0d mask=%b n=%0d: got %0d want %0d", k, mask, n, sel_state, m_sel);
      end
      if (k % 3 == 2) commit("rnd");
    end
  endtask
  task automatic test_reset_mid_repeat();
    hold(4'b1000, 5);
    hold(4'b0010, 6);
    commit("rst_pre");
    keys[1] = 1'b0;
    repeat (16) tick();
    sys_rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({b_lvl, g_lvl, r_lvl, rgb_lvl} !== '0 || sel_state !== 2'd0 || upd_pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got live=%h sel=%0d pend=%b want all 0",
               {b_lvl, g_lvl, r_lvl, rgb_lvl}, sel_state, upd_pending);
    end
    keys = 4'hF;
    repeat (2) tick();
    sys_rst = 1'b0;
    repeat (20) tick();
    commit("rst_post");
  endtask
  initial begin
    test_reset();
    test_glitch();
    test_press_commit();
    test_repeat();
    test_saturation();
    test_simultaneous();
    test_commit_timing();
    test_random();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
